// File: rtl/config_stream_loader_if.sv
// rtl/config_stream_loader_if.sv - word handshake bundle for config_stream_loader
// Carries the bitstream input words and the readback output words.
//   word_in_valid/ready/data   : bitstream words, master -> loader
//   word_out_valid/ready/data  : readback words, loader -> master
// The loader connects through the slave modport; the word source/sink uses master.
interface config_stream_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  word_in_valid;
  logic                  word_in_ready;
  logic [WORD_WIDTH-1:0] word_in_data;
  logic                  word_out_valid;
  logic                  word_out_ready;
  logic [WORD_WIDTH-1:0] word_out_data;

  modport master (
    output word_in_valid, word_in_data, word_out_ready,
    input  word_in_ready, word_out_valid, word_out_data
  );

  modport slave (
    input  word_in_valid, word_in_data, word_out_ready,
    output word_in_ready, word_out_valid, word_out_data
  );
endinterface

// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - serialises bitstream words into a configuration chain with optional readback
// Ports:
//   config_clock, config_nreset : clock, asynchronous active-low reset
//   start, readback_en          : begin a load (IDLE only), return old chain contents
//   bus (slave)                 : word_in / word_out handshakes
//   chain_out, chain_enable     : serial data and shift strobe into the chain head
//   chain_in                    : serial data from the chain tail
//   busy, done                  : not idle, one-cycle completion pulse
module config_stream_loader #(
  parameter int CHAIN_LENGTH = 4096,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                         config_clock,
  input  logic                         config_nreset,
  input  logic                         start,
  input  logic                         readback_en,
  config_stream_loader_if.slave        bus,
  output logic                         chain_out,
  input  logic                         chain_in,
  output logic                         chain_enable,
  output logic                         busy,
  output logic                         done
);
  localparam int NUM_WORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int BIT_CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int WRD_CNT_W = $clog2(NUM_WORDS + 1);
  localparam int POS_W     = $clog2(WORD_WIDTH);
  // Unused high bit positions of the final word; its readback is right-aligned by this much.
  localparam int PAD_BITS  = NUM_WORDS * WORD_WIDTH - CHAIN_LENGTH;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [WRD_CNT_W-1:0] LAST_WORD = WRD_CNT_W'(NUM_WORDS - 1);
  localparam logic [POS_W-1:0]     WORD_TOP  = POS_W'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  rb_q, rb_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WORD_WIDTH-1:0] rdbk_q, rdbk_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WRD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [POS_W-1:0]      pos_q, pos_d;

  logic                  last_bit;
  logic                  final_word;
  logic                  shift_en;
  logic [WORD_WIDTH-1:0] rdbk_next;

  assign bus.word_out_valid = out_valid_q;
  assign bus.word_out_data  = out_data_q;

  always_comb begin
    state_d           = state_q;
    rb_d              = rb_q;
    shift_d           = shift_q;
    rdbk_d            = rdbk_q;
    out_data_d        = out_data_q;
    out_valid_d       = out_valid_q;
    bit_cnt_d         = bit_cnt_q;
    word_cnt_d        = word_cnt_q;
    pos_d             = pos_q;
    chain_enable      = 1'b0;
    chain_out         = 1'b0;
    bus.word_in_ready = 1'b0;
    done              = 1'b0;
    busy              = (state_q != ST_IDLE);
    shift_en          = 1'b0;
    final_word        = (word_cnt_q == LAST_WORD);
    // A word ends on a full word or when the chain is full (short final word).
    last_bit          = (pos_q == WORD_TOP) || (bit_cnt_q == LAST_BIT);
    rdbk_next         = {chain_in, rdbk_q[WORD_WIDTH-1:1]};

    if (out_valid_q && bus.word_out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          rb_d       = readback_en;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        bus.word_in_ready = 1'b1;
        if (bus.word_in_valid) begin
          shift_d = bus.word_in_data;
          pos_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Only the word-completing shift needs room in the readback output register.
        shift_en = !(rb_q && last_bit && out_valid_q && !bus.word_out_ready);
        if (shift_en) begin
          chain_enable = 1'b1;
          chain_out    = shift_q[0];
          shift_d      = shift_q >> 1;
          rdbk_d       = rdbk_next;
          bit_cnt_d    = bit_cnt_q + BIT_CNT_W'(1);
          pos_d        = pos_q + POS_W'(1);
          if (last_bit) begin
            word_cnt_d = word_cnt_q + WRD_CNT_W'(1);
            if (rb_q) begin
              out_valid_d = 1'b1;
              out_data_d  = final_word ? (rdbk_next >> PAD_BITS) : rdbk_next;
            end
            state_d = final_word ? ST_DRAIN : ST_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (!rb_q || !out_valid_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q     <= ST_IDLE;
      rb_q        <= 1'b0;
      shift_q     <= '0;
      rdbk_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      pos_q       <= '0;
    end else begin
      state_q     <= state_d;
      rb_q        <= rb_d;
      shift_q     <= shift_d;
      rdbk_q      <= rdbk_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      pos_q       <= pos_d;
    end
  end
endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - self-checking bench for config_stream_loader
module tb_config_stream_loader;
  localparam int CL = 40;
  localparam int W  = 16;
  localparam int NW = (CL + W - 1) / W;

  typedef logic [NW-1:0][W-1:0] words_t;

  typedef struct packed {
    words_t        w;
    logic          rb;
    logic [CL-1:0] pre;
    logic [1:0]    mode;
    logic [7:0]    slen;
    logic [CL-1:0] exp_chain;
    words_t        exp_rb;
    logic [7:0]    exp_last8;
    logic [1:0]    exp_stall;
  } vec_t;

  logic config_clock = 1'b0;
  logic config_nreset = 1'b0;
  logic start = 1'b0;
  logic readback_en = 1'b0;
  logic chain_in, chain_out, chain_enable, busy, done;

  config_stream_loader_if #(.WORD_WIDTH(W)) bus ();

  config_stream_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(W)) dut (
    .config_clock (config_clock),
    .config_nreset(config_nreset),
    .start        (start),
    .readback_en  (readback_en),
    .bus          (bus.slave),
    .chain_out    (chain_out),
    .chain_in     (chain_in),
    .chain_enable (chain_enable),
    .busy         (busy),
    .done         (done)
  );

  always #5 config_clock = ~config_clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Chain model and observers
  logic [CL-1:0] chain_m = '0;
  logic [CL-1:0] stream_m = '0;
  logic [CL-1:0] preload_val = '0;
  logic          preload_req = 1'b0;
  logic          clr_req = 1'b1;
  logic          rb_mode = 1'b0;
  int            pulse_cnt = 0, done_cnt = 0, viol_cnt = 0, wov_off_cnt = 0, stall_cycles = 0;
  logic [W-1:0]  rb_got[$];

  assign chain_in = chain_m[0];

  always @(posedge config_clock) begin
    int v;
    v = 0;
    if (preload_req) chain_m <= preload_val;
    else if (chain_enable === 1'b1) chain_m <= {chain_out, chain_m[CL-1:1]};
    if (clr_req) begin
      pulse_cnt <= 0; done_cnt <= 0; viol_cnt <= 0; wov_off_cnt <= 0; stall_cycles <= 0;
      stream_m <= '0;
      rb_got.delete();
    end else begin
      if (chain_enable === 1'b1) begin
        if (pulse_cnt < CL) stream_m[pulse_cnt] <= chain_out;
        pulse_cnt <= pulse_cnt + 1;
        if (((pulse_cnt % W) == W - 1 || pulse_cnt == CL - 1) &&
            bus.word_out_valid === 1'b1 && bus.word_out_ready === 1'b0) v++;
        if (bus.word_in_ready === 1'b1) v++;
      end else if (chain_out !== 1'b0) v++;
      if (bus.word_in_ready === 1'b1 && busy !== 1'b1) v++;
      viol_cnt <= viol_cnt + v;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (!rb_mode && bus.word_out_valid !== 1'b0) wov_off_cnt <= wov_off_cnt + 1;
      if (busy === 1'b1 && bus.word_out_valid === 1'b1 && bus.word_out_ready === 1'b0 &&
          chain_enable === 1'b0 && bus.word_in_ready === 1'b0 && pulse_cnt > 0 && pulse_cnt < CL)
        stall_cycles <= stall_cycles + 1;
      if (bus.word_out_valid === 1'b1 && bus.word_out_ready === 1'b1) rb_got.push_back(bus.word_out_data);
    end
  end

  // Readback sink: 0 = always ready, 1 = random, 2 = hold low for stall_len cycles after first word
  int rdy_mode = 0, stall_len = 0, load_id = 0;
  int seen_id = 0, stall_left = 0;
  bit stalled = 1'b0;

  always @(negedge config_clock) begin
    if (load_id != seen_id) begin
      seen_id = load_id;
      stall_left = stall_len;
      stalled = 1'b0;
    end
    if (rdy_mode == 2) begin
      if (!stalled && bus.word_out_valid === 1'b1) stalled = 1'b1;
      if (stalled && stall_left > 0) begin
        bus.word_out_ready = 1'b0;
        stall_left--;
      end else bus.word_out_ready = 1'b1;
    end else if (rdy_mode == 1) bus.word_out_ready = 1'($urandom_range(0, 1));
    else bus.word_out_ready = 1'b1;
  end

  // Reference: bits enter the chain LSB-first word by word; readback returns the old chain in order.
  function automatic logic [CL-1:0] model_stream(input words_t w);
    logic [NW*W-1:0] flat;
    flat = '0;
    for (int k = 0; k < NW; k++) flat[k*W +: W] = w[k];
    return flat[CL-1:0];
  endfunction

  function automatic words_t model_rb(input logic [CL-1:0] pre);
    logic [NW*W-1:0] ext;
    words_t r;
    ext = '0;
    ext[CL-1:0] = pre;
    for (int k = 0; k < NW; k++) r[k] = ext[k*W +: W];
    return r;
  endfunction

  function automatic vec_t mk(input words_t w, input logic rb, input logic [CL-1:0] pre,
                              input logic [1:0] mode, input logic [7:0] slen, input logic [CL-1:0] ec,
                              input words_t erb, input logic [7:0] l8, input logic [1:0] st);
    vec_t v;
    v.w = w; v.rb = rb; v.pre = pre; v.mode = mode; v.slen = slen;
    v.exp_chain = ec; v.exp_rb = erb; v.exp_last8 = l8; v.exp_stall = st;
    return v;
  endfunction

  task automatic prep(input bit rb, input logic [CL-1:0] pre, input int mode, input int slen);
    rdy_mode = mode; stall_len = slen; rb_mode = rb; load_id++;
    preload_val = pre; preload_req = 1'b1; clr_req = 1'b1;
    @(negedge config_clock);
    preload_req = 1'b0; clr_req = 1'b0;
    start = 1'b1; readback_en = rb;
    @(negedge config_clock);
    start = 1'b0; readback_en = 1'($urandom_range(0, 1));
  endtask

  task automatic feed_word(input logic [W-1:0] d, input int gap);
    int n;
    repeat (gap) @(negedge config_clock);
    n = 0;
    while (bus.word_in_ready !== 1'b1 && n < 200) begin
      @(negedge config_clock);
      n++;
    end
    check("word_in_ready_wait", 64'(n < 200), 1);
    bus.word_in_valid = 1'b1;
    bus.word_in_data = d;
    @(negedge config_clock);
    bus.word_in_valid = 1'b0;
    bus.word_in_data = W'($urandom());
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge config_clock);
      n++;
    end
    check("done_wait", 64'(n < 1000), 1);
    repeat (2) @(negedge config_clock);
  endtask

  task automatic do_load(input words_t w, input bit rb, input logic [CL-1:0] pre,
                         input int mode, input int slen, input bit gaps);
    prep(rb, pre, mode, slen);
    for (int k = 0; k < NW; k++) feed_word(w[k], gaps ? int'($urandom_range(0, 3)) : 0);
    wait_done();
  endtask

  task automatic verify(input string tag, input logic [CL-1:0] exp_chain, input bit rb,
                        input words_t exp_rb, input logic [1:0] stall_exp);
    check({tag, "_pulses"}, pulse_cnt, CL);
    check({tag, "_stream"}, stream_m, exp_chain);
    check({tag, "_chain"}, chain_m, exp_chain);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_protocol"}, viol_cnt, 0);
    check({tag, "_wov_off"}, wov_off_cnt, 0);
    check({tag, "_idle_busy"}, busy, 0);
    if (rb) begin
      check({tag, "_rb_count"}, rb_got.size(), NW);
      for (int k = 0; k < NW; k++)
        if (k < rb_got.size()) check($sformatf("%s_rb%0d", tag, k), rb_got[k], exp_rb[k]);
    end else check({tag, "_rb_count"}, rb_got.size(), 0);
    if (stall_exp != 2'd2) check({tag, "_stalled"}, 64'(stall_cycles > 0), 64'(stall_exp[0]));
  endtask

  vec_t vecs[5];

  initial begin
    words_t spec_w;
    spec_w = {16'h1234, 16'h0FF0, 16'hA5A5};
    vecs[0] = mk(spec_w, 1'b0, 40'h0, 2'd0, 8'd0, 40'h34_0FF0_A5A5, '0, 8'h34, 2'd0);
    vecs[1] = mk(spec_w, 1'b1, 40'h12_3456_789A, 2'd0, 8'd0, 40'h34_0FF0_A5A5,
                 {16'h0012, 16'h3456, 16'h789A}, 8'h34, 2'd0);
    vecs[2] = mk(spec_w, 1'b1, 40'h12_3456_789A, 2'd2, 8'd10, 40'h34_0FF0_A5A5,
                 {16'h0012, 16'h3456, 16'h789A}, 8'h34, 2'd0);
    vecs[3] = mk(spec_w, 1'b1, 40'h12_3456_789A, 2'd2, 8'd30, 40'h34_0FF0_A5A5,
                 {16'h0012, 16'h3456, 16'h789A}, 8'h34, 2'd1);
    vecs[4] = mk({16'hFFAB, 16'h0000, 16'hFFFF}, 1'b1, 40'hC3_0F0F_F0F0, 2'd1, 8'd0,
                 40'hAB_0000_FFFF, {16'h00C3, 16'h0F0F, 16'hF0F0}, 8'hAB, 2'd2);

    bus.word_in_valid = 1'b0;
    bus.word_in_data = '0;

    // Reset state
    repeat (2) @(negedge config_clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_chain_enable", chain_enable, 0);
    check("rst_chain_out", chain_out, 0);
    check("rst_word_in_ready", bus.word_in_ready, 0);
    check("rst_word_out_valid", bus.word_out_valid, 0);
    check("rst_word_out_data", bus.word_out_data, 0);
    config_nreset = 1'b1;
    @(negedge config_clock);

    // Table-driven loads
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].w, vecs[i].rb, vecs[i].pre, int'(vecs[i].mode), int'(vecs[i].slen), 1'b0);
      verify($sformatf("vec%0d", i), vecs[i].exp_chain, vecs[i].rb, vecs[i].exp_rb, vecs[i].exp_stall);
      check($sformatf("vec%0d_last8", i), stream_m[CL-1:CL-8], vecs[i].exp_last8);
    end

    // Reset in the middle of shifting, then a fresh full load
    begin
      int n;
      prep(1'b1, 40'h12_3456_789A, 0, 0);
      feed_word(spec_w[0], 0);
      feed_word(spec_w[1], 0);
      n = 0;
      while (pulse_cnt < 20 && n < 200) begin
        @(negedge config_clock);
        n++;
      end
      check("midrst_wait", 64'(n < 200), 1);
      check("midrst_shifts", pulse_cnt, 20);
      config_nreset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_chain_enable", chain_enable, 0);
      check("midrst_chain_out", chain_out, 0);
      check("midrst_word_in_ready", bus.word_in_ready, 0);
      check("midrst_word_out_valid", bus.word_out_valid, 0);
      check("midrst_word_out_data", bus.word_out_data, 0);
      repeat (2) @(negedge config_clock);
      config_nreset = 1'b1;
      @(negedge config_clock);
      do_load(vecs[1].w, 1'b1, vecs[1].pre, 0, 0, 1'b0);
      verify("after_rst", vecs[1].exp_chain, 1'b1, vecs[1].exp_rb, 2'd0);
    end

    // start and word_in_valid while shifting are ignored
    prep(1'b0, '0, 0, 0);
    feed_word(spec_w[0], 0);
    start = 1'b1;
    bus.word_in_valid = 1'b1;
    bus.word_in_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ign_ready_shift%0d", i), bus.word_in_ready, 0);
      check($sformatf("ign_enable_shift%0d", i), chain_enable, 1);
      @(negedge config_clock);
      start = 1'b0;
    end
    bus.word_in_valid = 1'b0;
    feed_word(spec_w[1], 0);
    feed_word(spec_w[2], 0);
    wait_done();
    verify("ignore", vecs[0].exp_chain, 1'b0, '0, 2'd0);
    repeat (5) @(negedge config_clock);
    check("ignore_no_restart", busy, 0);

    // Randomised loads against the reference model
    for (int r = 0; r < 20; r++) begin
      words_t        w;
      logic [CL-1:0] pre;
      bit            rb;
      for (int k = 0; k < NW; k++) w[k] = W'($urandom());
      pre = CL'({$urandom(), $urandom()});
      rb = 1'($urandom_range(0, 1));
      do_load(w, rb, pre, 1, 0, 1'b1);
      verify($sformatf("rand%0d", r), model_stream(w), rb, model_rb(pre), 2'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
